// File: rtl/sram_arbiter2.sv
// sram_arbiter2: round-robin sharing of one asynchronous SRAM between two
// requesters. Each grant runs one fixed SETUP / ACCESS / DONE sequence. Every
// pin and handshake output is a register loaded from the next-state decode.
module sram_arbiter2 #(
  parameter int W_ADDR      = 18,
  parameter int W_DATA      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [W_ADDR-1:0] addr0,
  input  logic [W_ADDR-1:0] addr1,
  input  logic [W_DATA-1:0] wdata0,
  input  logic [W_DATA-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [W_DATA-1:0] rdata,
  output logic              busy,
  output logic [W_ADDR-1:0] sram_addr,
  input  logic [W_DATA-1:0] sram_data_in,
  output logic [W_DATA-1:0] sram_data_out,
  output logic              sram_data_oe,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we
);

  localparam int W_CNT = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic               sel, sel_nx;
  logic               wr, wr_nx;
  logic               rr_ptr, rr_ptr_nx;
  logic               grant;
  logic [W_CNT-1:0]   cnt, cnt_nx;
  logic [W_ADDR-1:0]  addr_nx;
  logic [W_DATA-1:0]  dout_nx, rdata_nx;
  logic               cs_nx, oe_nx, we_nx, doe_nx, ack0_nx, ack1_nx, busy_nx;

  // Next-state decode plus the values every output register takes in that state.
  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    wr_nx     = wr;
    rr_ptr_nx = rr_ptr;
    cnt_nx    = cnt;
    addr_nx   = sram_addr;
    dout_nx   = sram_data_out;
    rdata_nx  = rdata;
    grant     = 1'b0;
    cs_nx     = 1'b1;
    oe_nx     = 1'b1;
    we_nx     = 1'b1;
    doe_nx    = 1'b0;
    ack0_nx   = 1'b0;
    ack1_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie rr_ptr picks the winner; otherwise the lone requester wins.
          grant    = (req0 && req1) ? rr_ptr : req1;
          sel_nx   = grant;
          wr_nx    = grant ? we1 : we0;
          addr_nx  = grant ? addr1 : addr0;
          if (wr_nx) begin
            dout_nx = grant ? wdata1 : wdata0;
          end else begin
            dout_nx = sram_data_out;
          end
          state_nx = S_SETUP;
          cs_nx    = 1'b0;
          doe_nx   = wr_nx;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_SETUP: begin
        state_nx = S_ACCESS;
        cnt_nx   = W_CNT'(WAIT_CYCLES - 1);
        cs_nx    = 1'b0;
        doe_nx   = wr;
        we_nx    = ~wr;
        oe_nx    = wr;
      end
      S_ACCESS: begin
        cs_nx  = 1'b0;
        doe_nx = wr;
        if (cnt == W_CNT'(0)) begin
          // Last strobe cycle: capture read data on the edge that closes it.
          state_nx = S_DONE;
          if (!wr) begin
            rdata_nx = sram_data_in;
          end else begin
            rdata_nx = rdata;
          end
          if (sel) begin
            ack1_nx = 1'b1;
          end else begin
            ack0_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt - W_CNT'(1);
          we_nx  = ~wr;
          oe_nx  = wr;
        end
      end
      S_DONE: begin
        state_nx  = S_IDLE;
        rr_ptr_nx = ~sel;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  // State, latched request fields and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      sel           <= 1'b0;
      wr            <= 1'b0;
      rr_ptr        <= 1'b0;
      cnt           <= W_CNT'(0);
      sram_addr     <= {W_ADDR{1'b0}};
      sram_data_out <= {W_DATA{1'b0}};
      rdata         <= {W_DATA{1'b0}};
      sram_cs       <= 1'b1;
      sram_oe       <= 1'b1;
      sram_we       <= 1'b1;
      sram_data_oe  <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      sel           <= sel_nx;
      wr            <= wr_nx;
      rr_ptr        <= rr_ptr_nx;
      cnt           <= cnt_nx;
      sram_addr     <= addr_nx;
      sram_data_out <= dout_nx;
      rdata         <= rdata_nx;
      sram_cs       <= cs_nx;
      sram_oe       <= oe_nx;
      sram_we       <= we_nx;
      sram_data_oe  <= doe_nx;
      ack0          <= ack0_nx;
      ack1          <= ack1_nx;
      busy          <= busy_nx;
    end
  end

endmodule
